// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: end-of-test detector for riscv-tests runs on the Core.
// It only observes the Core's retire, gp and store signals and never drives them.
//
// Completion conventions (chosen by MODE):
//   MODE 0 : retirement of PASS_PC ends the test; x3 (gp) == 1 means pass.
//   MODE 1 : an odd store to TOHOST_ADDR ends the test; data == 1 means pass.
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   start, clear                run control pulses (clear has priority)
//   retire_valid, retire_pc     retire stream (MODE 0)
//   gp_value                    live value of x3 (MODE 0)
//   st_valid, st_addr, st_data  data store stream (MODE 1)
//   state                       IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4
//   done, pass                  terminal / passing status
//   fail_num                    failing test number (code >> 1), 0 unless FAIL
//   cycle_count, retire_count   saturating cycle and retire counts for the run
module riscv_test_monitor #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     MODE        = 0,
  parameter logic [XLEN-1:0] PASS_PC     = XLEN'(32'h44),
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(32'h1000),
  parameter int unsigned     TIMEOUT     = 5000,
  parameter int unsigned     CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic              retire_valid,
  input  logic [XLEN-1:0]   retire_pc,
  input  logic [XLEN-1:0]   gp_value,
  input  logic              st_valid,
  input  logic [XLEN-1:0]   st_addr,
  input  logic [XLEN-1:0]   st_data,
  output logic [2:0]        state,
  output logic              done,
  output logic              pass,
  output logic [XLEN-2:0]   fail_num,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retire_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  localparam bit               USE_TOHOST = (MODE != 0);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);

  state_t           st_q, st_n;
  logic             done_n, pass_n;
  logic [XLEN-2:0]  fn_n;
  logic [CNT_W-1:0] cc_n, rc_n;

  // Completion event and its result code for the selected convention only
  logic             pc_hit, tohost_hit, hit;
  logic [XLEN-1:0]  code;

  assign pc_hit     = retire_valid && (retire_pc == PASS_PC);
  assign tohost_hit = st_valid && (st_addr == TOHOST_ADDR) && st_data[0];
  assign hit        = USE_TOHOST ? tohost_hit : pc_hit;
  assign code       = USE_TOHOST ? st_data : gp_value;

  assign state = st_q;

  // Next-state and next-output computation
  always_comb begin
    st_n = st_q;
    fn_n = fail_num;
    cc_n = cycle_count;
    rc_n = retire_count;
    if (clear) begin
      // Counters deliberately hold so the last run can still be read back
      st_n = S_IDLE;
      fn_n = '0;
    end else begin
      case (st_q)
        S_IDLE: begin
          if (start) begin
            st_n = S_RUN;
            cc_n = '0;
            rc_n = '0;
          end
        end
        S_RUN: begin
          // The completing cycle is still counted
          if (cycle_count != CNT_MAX) cc_n = cycle_count + CNT_W'(1);
          if (retire_valid && (retire_count != CNT_MAX)) rc_n = retire_count + CNT_W'(1);
          if (hit) begin
            if (code == XLEN'(1)) begin
              st_n = S_PASS;
            end else begin
              st_n = S_FAIL;
              fn_n = code[XLEN-1:1];
            end
          end else if (cycle_count == TO_LAST) begin
            st_n = S_TIMEOUT;
          end
        end
        default: ;  // terminal states are sticky until clear
      endcase
    end
    done_n = (st_n == S_PASS) || (st_n == S_FAIL) || (st_n == S_TIMEOUT);
    pass_n = (st_n == S_PASS);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q         <= S_IDLE;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_num     <= '0;
      cycle_count  <= '0;
      retire_count <= '0;
    end else begin
      st_q         <= st_n;
      done         <= done_n;
      pass         <= pass_n;
      fail_num     <= fn_n;
      cycle_count  <= cc_n;
      retire_count <= rc_n;
    end
  end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Bench for riscv_test_monitor: one MODE 0 and one MODE 1 instance share the
// same stimulus, both with TIMEOUT=20.
module tb_riscv_test_monitor;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  localparam logic [2:0] IDLE = 3'd0, RUN = 3'd1, PASS = 3'd2, FAILST = 3'd3, TMO = 3'd4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, clear = 1'b0;
  logic retire_valid = 1'b0, st_valid = 1'b0;
  logic [XLEN-1:0] retire_pc = '0, gp_value = '0, st_addr = '0, st_data = '0;

  logic [2:0]       state0, state1;
  logic             done0, done1, pass0, pass1;
  logic [XLEN-2:0]  fn0, fn1;
  logic [CNT_W-1:0] cc0, cc1, rc0, rc1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  riscv_test_monitor #(.XLEN(XLEN), .MODE(0), .TIMEOUT(20), .CNT_W(CNT_W)) u0 (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .gp_value(gp_value),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .state(state0), .done(done0), .pass(pass0), .fail_num(fn0),
    .cycle_count(cc0), .retire_count(rc0)
  );

  riscv_test_monitor #(.XLEN(XLEN), .MODE(1), .TIMEOUT(20), .CNT_W(CNT_W)) u1 (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .gp_value(gp_value),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .state(state1), .done(done1), .pass(pass1), .fail_num(fn1),
    .cycle_count(cc1), .retire_count(rc1)
  );

  typedef struct {
    logic        start, clear, rv;
    logic [31:0] pc, gp;
    logic        sv;
    logic [31:0] sa, sd;
    logic [2:0]  s0;
    logic [15:0] cc0, rc0;
    logic [30:0] fn0;
    logic [2:0]  s1;
    logic [15:0] cc1;
    logic [30:0] fn1;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input logic st, cl, rv, input logic [31:0] pc, gp,
                              input logic sv, input logic [31:0] sa, sd,
                              input logic [2:0] s0, input logic [15:0] c0, r0,
                              input logic [30:0] f0, input logic [2:0] s1,
                              input logic [15:0] c1, input logic [30:0] f1);
    vec_t v;
    v.start = st; v.clear = cl; v.rv = rv; v.pc = pc; v.gp = gp;
    v.sv = sv; v.sa = sa; v.sd = sd;
    v.s0 = s0; v.cc0 = c0; v.rc0 = r0; v.fn0 = f0;
    v.s1 = s1; v.cc1 = c1; v.fn1 = f1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Compare the full status of one instance against an expected state
  task automatic chk_inst(input string tag, input int idx, input logic [2:0] es,
                          input logic [15:0] ecc, input logic [30:0] efn);
    logic [2:0] s; logic d, p; logic [30:0] f; logic [15:0] c;
    if (idx == 0) begin s = state0; d = done0; p = pass0; f = fn0; c = cc0; end
    else          begin s = state1; d = done1; p = pass1; f = fn1; c = cc1; end
    chk($sformatf("%s u%0d state", tag, idx), 32'(s), 32'(es));
    chk($sformatf("%s u%0d done", tag, idx), 32'(d), 32'(es >= PASS));
    chk($sformatf("%s u%0d pass", tag, idx), 32'(p), 32'(es == PASS));
    chk($sformatf("%s u%0d fail_num", tag, idx), 32'(f), 32'(efn));
    chk($sformatf("%s u%0d cycle_count", tag, idx), 32'(c), 32'(ecc));
  endtask

  // Apply inputs for one cycle, then sample just after the rising edge
  task automatic drive(input logic st, cl, rv, input logic [31:0] pc, gp,
                       input logic sv, input logic [31:0] sa, sd);
    @(negedge clk);
    start = st; clear = cl; retire_valid = rv; retire_pc = pc; gp_value = gp;
    st_valid = sv; st_addr = sa; st_data = sd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Shared sequence; both instances see every input
    tbl[0]  = mk(0,0,1,32'h44,1, 0,0,0,            IDLE,  0,0,0, IDLE,  0,0);
    tbl[1]  = mk(1,0,0,0,0,      0,0,0,            RUN,   0,0,0, RUN,   0,0);
    tbl[2]  = mk(0,0,1,32'h40,7, 1,32'h1000,32'h2, RUN,   1,1,0, RUN,   1,0);
    tbl[3]  = mk(0,0,1,32'h44,7, 0,0,0,            FAILST,2,2,3, RUN,   2,0);
    tbl[4]  = mk(0,0,1,32'h44,1, 1,32'h1004,32'h15,FAILST,2,2,3, RUN,   3,0);
    tbl[5]  = mk(1,0,0,0,0,      1,32'h1000,32'h15,FAILST,2,2,3, FAILST,4,10);
    tbl[6]  = mk(0,1,0,0,0,      0,0,0,            IDLE,  2,2,0, IDLE,  4,0);
    tbl[7]  = mk(1,0,0,0,0,      0,0,0,            RUN,   0,0,0, RUN,   0,0);
    tbl[8]  = mk(0,1,1,32'h44,1, 1,32'h1000,32'h1, IDLE,  0,0,0, IDLE,  0,0);
    tbl[9]  = mk(1,0,1,32'h44,5, 1,32'h1000,32'h5, RUN,   0,0,0, RUN,   0,0);
    tbl[10] = mk(0,0,1,32'h44,1, 1,32'h1000,32'h1, PASS,  1,1,0, PASS,  1,0);
    tbl[11] = mk(0,1,0,0,0,      0,0,0,            IDLE,  1,1,0, IDLE,  1,0);
    tbl[12] = mk(1,0,1,32'h0,0,  0,0,0,            RUN,   0,0,0, RUN,   0,0);
    tbl[13] = mk(1,0,1,32'h0,0,  0,0,0,            RUN,   1,1,0, RUN,   1,0);
    tbl[14] = mk(0,1,0,0,0,      0,0,0,            IDLE,  1,1,0, IDLE,  1,0);

    // Reset state
    #2;
    chk_inst("reset", 0, IDLE, 0, 0);
    chk_inst("reset", 1, IDLE, 0, 0);
    chk("reset u0 retire_count", 32'(rc0), 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].start, tbl[i].clear, tbl[i].rv, tbl[i].pc, tbl[i].gp,
            tbl[i].sv, tbl[i].sa, tbl[i].sd);
      chk_inst($sformatf("vec%0d", i), 0, tbl[i].s0, tbl[i].cc0, tbl[i].fn0);
      chk_inst($sformatf("vec%0d", i), 1, tbl[i].s1, tbl[i].cc1, tbl[i].fn1);
      chk($sformatf("vec%0d u0 retire_count", i), 32'(rc0), 32'(tbl[i].rc0));
    end

    // MODE 0 pass after 10 run cycles; MODE 1 keeps running into timeout
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle_cycles(10);
    drive(0, 0, 1, 32'h44, 1, 0, 0, 0);
    chk_inst("pc_pass", 0, PASS, 11, 0);
    chk("pc_pass u0 retire_count", 32'(rc0), 1);
    chk_inst("pc_pass", 1, RUN, 11, 0);
    idle_cycles(8);
    chk_inst("pre_tmo", 1, RUN, 19, 0);
    idle_cycles(1);
    chk_inst("tmo", 1, TMO, 20, 0);
    chk_inst("tmo sticky", 0, PASS, 11, 0);
    drive(1, 0, 1, 32'h44, 7, 1, 32'h1000, 32'h7);
    chk_inst("tmo hold", 1, TMO, 20, 0);
    chk_inst("pass hold", 0, PASS, 11, 0);

    // Completion on the final cycle beats timeout
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle_cycles(19);
    chk_inst("last pre", 0, RUN, 19, 0);
    drive(0, 0, 1, 32'h44, 1, 1, 32'h1000, 32'h1);
    chk_inst("last win", 0, PASS, 20, 0);
    chk_inst("last win", 1, PASS, 20, 0);

    // Asynchronous reset mid-run
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h10, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h14, 0, 0, 0, 0);
    chk_inst("pre_rst", 0, RUN, 2, 0);
    #2;
    rst = 1'b0;
    #1;
    chk_inst("async_rst", 0, IDLE, 0, 0);
    chk_inst("async_rst", 1, IDLE, 0, 0);
    chk("async_rst u0 retire_count", 32'(rc0), 0);
    chk("async_rst u1 retire_count", 32'(rc1), 0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 1, 32'h18, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h44, 1, 0, 0, 0);
    chk_inst("idle retire", 0, IDLE, 0, 0);
    chk("idle retire u0 retire_count", 32'(rc0), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
